// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl
//   Serial-configured delay timer. Searches the serial input for the start
//   pattern. It then shifts in a DELAY_W-bit delay value, MSB first, and
//   counts (delay+1)*CYCLES_PER_UNIT clock cycles. After that it raises
//   o_done and holds it until o_done is acknowledged.
//
//   Build option: define TIMER_ABORT_EN to make i_abort functional. When it
//   is undefined, the port is present but ignored.
//
// Ports
//   i_clk        rising-edge clock
//   i_reset      asynchronous reset, active low
//   i_data       serial input, sampled every rising edge
//   i_ack        done acknowledge, only honoured in DONE
//   i_abort      cancel request (TIMER_ABORT_EN builds only)
//   o_shift_ena  high during the DELAY_W delay-shift cycles
//   o_counting   high for the whole count phase
//   o_done       high in DONE
//   o_count      remaining whole units; the shift register while shifting
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | no pattern bits matched
// S1       | matched "1"
// S11      | matched "11"
// S110     | matched "110"
// SHIFT    | shifting in the delay value (r_sub = bit index)
// COUNT    | counting units; r_presc divides the clock
// DONE     | timer expired, waiting for i_ack
module timer_seq_ctrl #(
  parameter logic [3:0] PATTERN         = 4'b1101,
  parameter int         DELAY_W         = 4,
  parameter int         CYCLES_PER_UNIT = 1000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_data,
  input  logic               i_ack,
  input  logic               i_abort,
  output logic               o_shift_ena,
  output logic               o_counting,
  output logic               o_done,
  output logic [DELAY_W-1:0] o_count
);

  localparam int PW = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
  localparam int SW = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CYCLES_PER_UNIT - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(DELAY_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_S1, ST_S11, ST_S110, ST_SHIFT, ST_COUNT, ST_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [DELAY_W-1:0] r_count, w_count_nxt;
  logic [PW-1:0]      r_presc, w_presc_nxt;
  logic [SW-1:0]      r_sub,   w_sub_nxt;

`ifndef TIMER_ABORT_EN
  logic w_unused_abort;
  assign w_unused_abort = i_abort;
`endif

  // The detector states are shaped for a 1101-type pattern. A miss falls back
  // to the longest prefix that still matches: extra leading 1s keep S11, and
  // every other miss returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_presc_nxt = r_presc;
    w_sub_nxt   = r_sub;
    case (r_state)
      ST_IDLE: begin
        if (i_data == PATTERN[3]) w_state_nxt = ST_S1;
      end
      ST_S1: begin
        w_state_nxt = (i_data == PATTERN[2]) ? ST_S11 : ST_IDLE;
      end
      ST_S11: begin
        w_state_nxt = (i_data == PATTERN[1]) ? ST_S110 : ST_S11;
      end
      ST_S110: begin
        if (i_data == PATTERN[0]) begin
          w_state_nxt = ST_SHIFT;
          w_sub_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // r_count doubles as the delay shift register, so COUNT starts with
        // the assembled value already in place.
        w_count_nxt = {r_count[DELAY_W-2:0], i_data};
        if (r_sub == SUB_LAST) begin
          w_state_nxt = ST_COUNT;
          w_presc_nxt = '0;
          w_sub_nxt   = '0;
        end else begin
          w_sub_nxt = r_sub + SW'(1);
        end
      end
      ST_COUNT: begin
        // The unit in which count==0 still runs in full, which gives
        // (delay+1) units in total.
        if (r_presc == PRE_LAST) begin
          w_presc_nxt = '0;
          if (r_count != '0) w_count_nxt = r_count - DELAY_W'(1);
          else               w_state_nxt = ST_DONE;
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
      ST_DONE: begin
        if (i_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_presc <= '0;
      r_sub   <= '0;
    end
`ifdef TIMER_ABORT_EN
    else if (i_abort) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_presc <= '0;
      r_sub   <= '0;
    end
`endif
    else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_presc <= w_presc_nxt;
      r_sub   <= w_sub_nxt;
    end
  end

  assign o_shift_ena = (r_state == ST_SHIFT);
  assign o_counting  = (r_state == ST_COUNT);
  assign o_done      = (r_state == ST_DONE);
  assign o_count     = r_count;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
module tb_timer_seq_ctrl;
  localparam int CPU = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data = 1'b0;
  logic       ack = 1'b0;
  logic       abort = 1'b0;
  logic       shift_ena, counting, done;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  timer_seq_ctrl #(
    .PATTERN(4'b1101), .DELAY_W(4), .CYCLES_PER_UNIT(CPU)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_data(data), .i_ack(ack), .i_abort(abort),
    .o_shift_ena(shift_ena), .o_counting(counting), .o_done(done), .o_count(count)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Apply inputs just after an edge. They are sampled at the next edge, and
  // the outputs are observed 1 time unit after that edge.
  task automatic drive(input logic d, input logic a, input logic ab);
    data = d; ack = a; abort = ab;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    data = 1'b0; ack = 1'b0; abort = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send_start(input logic [3:0] dly);
    drive(1'b1, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) drive(dly[i], 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({shift_ena, counting, done, count} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0000000", {shift_ena, counting, done, count});
    end
    rst_n = 1'b1;
    data = 1'b0; ack = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] bits;
    bits = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      drive(bits[i], 1'b0, 1'b0);
      n_checks++;
      if (shift_ena !== (i == 0)) begin
        n_fail++;
        $display("FAIL basic_detect bit%0d: shift_ena got %b want %b", 3 - i, shift_ena, (i == 0));
      end
    end
    bits = 4'b0010;
    for (int i = 3; i >= 0; i--) begin
      drive(bits[i], 1'b0, 1'b0);
      n_checks++;
      if (i > 0 && {shift_ena, counting} !== 2'b10) begin
        n_fail++;
        $display("FAIL basic_shift bit%0d: shift/counting got %b want 10", 3 - i, {shift_ena, counting});
      end else if (i == 0 && {shift_ena, counting, done, count} !== {3'b010, 4'd2}) begin
        n_fail++;
        $display("FAIL basic_shift_end: got %b want 0100010", {shift_ena, counting, done, count});
      end
    end
    for (int k = 0; k < 3 * CPU; k++) begin
      n_checks++;
      if ({counting, done, count} !== {2'b10, 4'(2 - k / CPU)}) begin
        n_fail++;
        $display("FAIL basic_count cyc%0d: got %b want %b", k, {counting, done, count}, {2'b10, 4'(2 - k / CPU)});
      end
      drive(1'($urandom), 1'b0, 1'b0);
    end
    n_checks++;
    if ({shift_ena, counting, done, count} !== 7'b0010000) begin
      n_fail++;
      $display("FAIL basic_done: got %b want 0010000", {shift_ena, counting, done, count});
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'($urandom), 1'b0, 1'b0);
      n_checks++;
      if ({counting, done} !== 2'b01) begin
        n_fail++;
        $display("FAIL done_hold cyc%0d: got %b want 01", k, {counting, done});
      end
    end
    drive(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_clears: done got %b want 0", done);
    end
    // The data bit on the ack edge must not count toward the next pattern.
    bits = 4'b0101;
    for (int i = 3; i >= 0; i--) drive(bits[i], 1'b0, 1'b0);
    n_checks++;
    if (shift_ena !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_edge_ignored: shift_ena got %b want 0", shift_ena);
    end
    bits = 4'b1101;
    for (int i = 3; i >= 0; i--) drive(bits[i], 1'b0, 1'b0);
    n_checks++;
    if (shift_ena !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_detect: shift_ena got %b want 1", shift_ena);
    end
  endtask

  task automatic test_overlap();
    logic [4:0] s5;
    logic [7:0] s8;
    do_reset();
    s5 = 5'b11101;
    for (int i = 4; i >= 0; i--) begin
      drive(s5[i], 1'b0, 1'b0);
      n_checks++;
      if (shift_ena !== (i == 0)) begin
        n_fail++;
        $display("FAIL overlap5 bit%0d: shift_ena got %b want %b", 4 - i, shift_ena, (i == 0));
      end
    end
    do_reset();
    s8 = 8'b11001101;
    for (int i = 7; i >= 0; i--) begin
      drive(s8[i], 1'b0, 1'b0);
      n_checks++;
      if (shift_ena !== (i == 0)) begin
        n_fail++;
        $display("FAIL overlap8 bit%0d: shift_ena got %b want %b", 7 - i, shift_ena, (i == 0));
      end
    end
  endtask

  task automatic test_delay_bounds();
    int n;
    logic [3:0] dl [2];
    dl[0] = 4'd0; dl[1] = 4'd15;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      send_start(dl[t]);
      n = 0;
      while (counting === 1'b1 && n < 200) begin
        n++;
        drive(1'($urandom), 1'b0, 1'b0);
      end
      n_checks++;
      if (n != (dl[t] + 1) * CPU || done !== 1'b1) begin
        n_fail++;
        $display("FAIL delay_bound d=%0d: counting cycles %0d done %b want %0d done 1", dl[t], n, done, (dl[t] + 1) * CPU);
      end
      drive(1'b0, 1'b1, 1'b0);
    end
    do_reset();
    send_start(4'd9);
    repeat (6) drive(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({shift_ena, counting, done, count} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %b want 0000000", {shift_ena, counting, done, count});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_abort();
    int n;
    do_reset();
    send_start(4'd2);
    n = 0;
    while (counting === 1'b1 && n < 100) begin
      n++;
      drive(1'b0, 1'b0, (n == 6));
    end
`ifdef TIMER_ABORT_EN
    n_checks++;
    if (n != 6 || {shift_ena, counting, done, count} !== 7'b0) begin
      n_fail++;
      $display("FAIL abort_count: cycles %0d outs %b want 6 and 0000000", n, {shift_ena, counting, done, count});
    end
    send_start(4'd0);
    n_checks++;
    if (counting !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_restart: counting got %b want 1", counting);
    end
`else
    n_checks++;
    if (n != 3 * CPU || done !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ignored: cycles %0d done %b want %0d done 1", n, done, 3 * CPU);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] hist, pat, d;
    logic b, det;
    int nb, w;
    pat = 4'b1101;
    do_reset();
    for (int t = 0; t < 8; t++) begin
      hist = 4'b0; nb = 0; det = 1'b0;
      // Random noise first; after 40 bits repeat the pattern so a match
      // is guaranteed.
      while (!det && nb < 60) begin
        b = (nb < 40) ? 1'($urandom) : pat[3 - ((nb - 40) % 4)];
        drive(b, 1'($urandom), 1'b0);
        hist = {hist[2:0], b};
        nb++;
        det = (nb >= 4 && hist == pat);
        n_checks++;
        if (shift_ena !== det) begin
          n_fail++;
          $display("FAIL rand_detect t%0d bit%0d: shift_ena got %b want %b", t, nb, shift_ena, det);
        end
      end
      if (!det) begin
        n_checks++; n_fail++;
        $display("FAIL rand_detect_timeout t%0d: got none want a match", t);
      end
      d = 4'($urandom_range(0, 15));
      for (int i = 3; i >= 0; i--) begin
        drive(d[i], 1'($urandom), 1'b0);
        if (i == 0) begin
          n_checks++;
          if ({shift_ena, counting, done, count} !== {3'b010, d}) begin
            n_fail++;
            $display("FAIL rand_shift_end t%0d: got %b want %b", t, {shift_ena, counting, done, count}, {3'b010, d});
          end
        end
      end
      for (int k = 0; k < (d + 1) * CPU; k++) begin
        n_checks++;
        if ({counting, done, count} !== {2'b10, 4'(d - k / CPU)}) begin
          n_fail++;
          $display("FAIL rand_count t%0d cyc%0d: got %b want %b", t, k, {counting, done, count}, {2'b10, 4'(d - k / CPU)});
        end
        drive(1'($urandom), 1'($urandom), 1'b0);
      end
      w = $urandom_range(0, 4);
      for (int k = 0; k <= w; k++) begin
        n_checks++;
        if ({counting, done} !== 2'b01) begin
          n_fail++;
          $display("FAIL rand_done t%0d: got %b want 01", t, {counting, done});
        end
        drive(1'($urandom), (k == w), 1'b0);
      end
      n_checks++;
      if ({shift_ena, counting, done} !== 3'b000) begin
        n_fail++;
        $display("FAIL rand_ack t%0d: got %b want 000", t, {shift_ena, counting, done});
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_overlap();
    test_delay_bounds();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
